audio_seq: RTL and testbench

AUDIO_SEQ -- requirements
Module: audio_seq

---
 rtl/audio_seq.sv | 112 +++++++++++
 tb/tb_audio_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/audio_seq.sv
// Note sequencer: plays a square-wave tone for a coded duration, then holds a
// silent gap and strobes cont so the stalled control unit can continue.
module audio_seq #(
    parameter int unsigned TICK_DIV   = 1250000,
    parameter int unsigned GAP_CYCLES = 125000,
    parameter int unsigned HP_STEP    = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       audioreg,
    input  logic       audioact,
    input  logic [7:0] data_in,
    output logic       speaker,
    output logic       cont,
    output logic       busy
);

    localparam int unsigned DUR_W = $clog2(8 * TICK_DIV + 1);
    localparam int unsigned HP_W  = $clog2(31 * HP_STEP + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

    state_t           state;
    logic [7:0]       note_reg;
    logic [4:0]       tone_s;
    logic [2:0]       dur_s;
    logic [DUR_W-1:0] dur_cnt;
    logic [HP_W-1:0]  hp_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic [7:0]       snap;
    logic [DUR_W-1:0] play_last;
    logic [HP_W-1:0]  hp_last;
    logic [GAP_W-1:0] gap_last;

    // A strobe on the same edge as the play request bypasses the note register.
    always_comb begin
        snap      = audioreg ? data_in : note_reg;
        play_last = DUR_W'((32'(dur_s) + 32'd1) * TICK_DIV - 32'd1);
        hp_last   = HP_W'(32'(tone_s) * HP_STEP - 32'd1);
        gap_last  = GAP_W'(GAP_CYCLES - 32'd1);
    end

    assign cont = (state == DONE);
    assign busy = (state == PLAY) || (state == GAP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            note_reg <= '0;
            tone_s   <= '0;
            dur_s    <= '0;
            dur_cnt  <= '0;
            hp_cnt   <= '0;
            gap_cnt  <= '0;
            speaker  <= 1'b0;
        end else begin
            if (audioreg)
                note_reg <= data_in;

            case (state)
                IDLE: begin
                    speaker <= 1'b0;
                    if (audioact) begin
                        state   <= PLAY;
                        tone_s  <= snap[7:3];
                        dur_s   <= snap[2:0];
                        dur_cnt <= '0;
                        hp_cnt  <= '0;
                    end
                end
                PLAY: begin
                    if (!audioact) begin
                        state   <= IDLE;
                        speaker <= 1'b0;
                    end else if (dur_cnt == play_last) begin
                        state   <= GAP;
                        speaker <= 1'b0;
                        gap_cnt <= '0;
                    end else begin
                        dur_cnt <= dur_cnt + 1'b1;
                        // Rests keep the half-period counter parked and the speaker low.
                        if (tone_s != '0) begin
                            if (hp_cnt == hp_last) begin
                                hp_cnt  <= '0;
                                speaker <= ~speaker;
                            end else begin
                                hp_cnt <= hp_cnt + 1'b1;
                            end
                        end
                    end
                end
                GAP: begin
                    speaker <= 1'b0;
                    if (!audioact)
                        state <= IDLE;
                    else if (gap_cnt == gap_last)
                        state <= DONE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                DONE: begin
                    speaker <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_seq.sv
// Scoreboarded bench for audio_seq: the stimulus pushes the cycle at which each
// cont pulse is due, a monitor pops and compares whenever cont is seen.
module tb_audio_seq;

    localparam int unsigned TD = 10;
    localparam int unsigned GC = 4;
    localparam int unsigned HS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       audioreg = 1'b0;
    logic       audioact = 1'b0;
    logic [7:0] data_in = '0;
    logic       speaker;
    logic       cont;
    logic       busy;

    int unsigned cyc = 0;
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned exp_q[$];

    audio_seq #(.TICK_DIV(TD), .GAP_CYCLES(GC), .HP_STEP(HS)) dut (
        .clk(clk), .reset(reset), .audioreg(audioreg), .audioact(audioact),
        .data_in(data_in), .speaker(speaker), .cont(cont), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cont === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL cont_unexpected: got pulse at cycle %0d, expected none", cyc);
            end else begin
                check("cont_cycle", cyc, exp_q.pop_front());
            end
        end
    end

    // Caller has set up data_in/audioreg at a negedge; the next posedge is E0.
    task automatic run_note(input int unsigned tone, input int unsigned dur,
                            input int unsigned abort_k, input int unsigned reset_k,
                            input int unsigned mid_k, input bit keep);
        int unsigned len;
        int unsigned c0;
        int unsigned exp_spk;
        len = (dur + 1) * TD;
        c0  = cyc + 1;
        audioact = 1'b1;
        if (abort_k == 0 && reset_k == 0)
            exp_q.push_back(c0 + len + GC);
        for (int unsigned k = 1; k <= len + GC + 1; k++) begin
            @(negedge clk);
            if (k == 1) audioreg = 1'b0;
            exp_spk = (k <= len && tone != 0) ? ((k - 1) / (HS * tone)) % 2 : 0;
            check("busy", busy, (k <= len + GC) ? 1 : 0);
            check("speaker", speaker, exp_spk);
            if (k == abort_k) begin
                audioact = 1'b0;
                @(negedge clk);
                check("abort_busy", busy, 0);
                check("abort_speaker", speaker, 0);
                return;
            end
            if (k == reset_k) begin
                #2 reset = 1'b1;
                #1;
                check("rst_busy", busy, 0);
                check("rst_speaker", speaker, 0);
                check("rst_cont", cont, 0);
                return;
            end
            if (mid_k != 0 && k == mid_k) begin
                audioreg = 1'b1;
                data_in  = 8'h08;
            end
            if (mid_k != 0 && k == mid_k + 1) audioreg = 1'b0;
            if (k == len + GC + 1 && !keep) audioact = 1'b0;
        end
        if (keep) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #2;
        check("reset_speaker", speaker, 0);
        check("reset_cont", cont, 0);
        check("reset_busy", busy, 0);
        idle(2);
        reset = 1'b0;
        idle(2);

        // Load 8'h19 (tone 3, duration 1) then play.
        audioreg = 1'b1; data_in = 8'h19;
        @(negedge clk);
        audioreg = 1'b0;
        run_note(3, 1, 0, 0, 0, 1'b0);
        idle(3);

        // Rest note, bypassed on the play edge.
        audioreg = 1'b1; data_in = 8'h00;
        run_note(0, 0, 0, 0, 0, 1'b0);
        idle(3);

        // Back-to-back with audioact held: pulses 26 edges apart (one IDLE cycle between).
        audioreg = 1'b1; data_in = 8'h19;
        run_note(3, 1, 0, 0, 0, 1'b1);
        run_note(3, 1, 0, 0, 0, 1'b0);
        idle(3);

        // Abort in PLAY cycle 7; note register still holds 8'h19.
        run_note(3, 1, 7, 0, 0, 1'b0);
        idle(40);

        // Same-edge bypass of 8'h27, mid-note load of 8'h08 used by the next note.
        audioreg = 1'b1; data_in = 8'h27;
        run_note(4, 7, 0, 0, 10, 1'b0);
        idle(3);
        run_note(1, 0, 0, 0, 0, 1'b0);
        idle(3);

        // Asynchronous reset in GAP cycle 2, then replay from the cleared register.
        audioreg = 1'b1; data_in = 8'h19;
        run_note(3, 1, 0, 22, 0, 1'b0);
        @(negedge clk);
        audioact = 1'b0;
        reset = 1'b0;
        idle(40);
        run_note(0, 0, 0, 0, 0, 1'b0);
        idle(5);

        check("pending_cont", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
